// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_rx path: receiver state encoding,
// bit-index width and the clocks-per-bit calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  // Wide enough to index up to 8 data bits.
  localparam int BIT_IDX_W = 3;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Byte handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: ticks on the terminal count, half-period preload
// lets the first tick land in the middle of the start bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic load_half_i,
  output logic tick_o
);

  localparam int             CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_half_i) begin
      cnt_d = HALF;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer with valid/ready byte output.
// Parity bit handling is built only when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_in,
  uart_rx_ctrl_if.master rx_bus,
  output logic           busy,
  output logic           frame_err,
  output logic           overrun_err,
  output logic           parity_err
);

  localparam int                    CPB      = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

  if (CPB < 4 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD < 0 || PARITY_ODD > 1)
  begin : g_bad_param
    $error("uart_rx_ctrl: unsupported parameter combination");
  end

  rx_state_e             state_q, state_d;
  logic [BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  data_q;
  logic                  valid_q;
  logic                  rx_meta_q, rx_s_q;
  logic                  tick, tick_en, load_half, deliver;

  // Two-flop synchronizer, idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign tick_en   = (state_q == START) || (state_q == DATA) ||
                     (state_q == PARITY) || (state_q == STOP);
  assign load_half = (state_q == IDLE) && !rx_s_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CPB)
  ) u_baud_tick (
    .clk        (clk),
    .rst        (rst),
    .en_i       (tick_en),
    .load_half_i(load_half),
    .tick_o     (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
`endif

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    frame_err = 1'b0;
    deliver   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (tick) begin
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_bad_d = rx_s_q ^ (^shift_q) ^ (PARITY_ODD != 0);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (rx_s_q) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      frame_err = 1'b0;
      deliver   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad_q <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
    end
  end

  assign parity_err = deliver && par_bad_q;
`else
  assign parity_err = 1'b0;
`endif

  // A held byte is only replaced when the consumer takes it in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (deliver && (!valid_q || rx_bus.rx_ready)) begin
      data_q  <= shift_q;
      valid_q <= 1'b1;
    end else if (valid_q && rx_bus.rx_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign overrun_err     = deliver && valid_q && !rx_bus.rx_ready;
  assign busy            = (state_q != IDLE);
  assign rx_bus.rx_data  = data_q;
  assign rx_bus.rx_valid = valid_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl at 10 clocks per bit; parity scenario
// is built when UART_RX_PARITY_EN is defined.
module tb_uart_rx_ctrl;

  logic clk;
  logic rst;
  logic rxIn;
  logic busy;
  logic frameErr;
  logic overrunErr;
  logic parityErr;

  int checks   = 0;
  int failures = 0;

  int cycleCnt    = 0;
  int validRise   = 0;
  int validCycles = 0;
  int riseCycle   = 0;
  int frameCnt    = 0;
  int overrunCnt  = 0;
  int parityCnt   = 0;
  logic [7:0] lastData = 8'h00;
  logic prevValid = 1'b0;
  int startCycle  = 0;

  uart_rx_ctrl_if #(.DATA_BITS(8)) rxIf ();

  uart_rx_ctrl #(
    .CLK_FREQ  (1000000),
    .BAUD      (100000),
    .DATA_BITS (8),
    .PARITY_ODD(0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rxIn),
    .rx_bus     (rxIf),
    .busy       (busy),
    .frame_err  (frameErr),
    .overrun_err(overrunErr),
    .parity_err (parityErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Event monitor sampled away from the active edge.
  always @(negedge clk) begin
    if (frameErr)   frameCnt   <= frameCnt + 1;
    if (overrunErr) overrunCnt <= overrunCnt + 1;
    if (parityErr)  parityCnt  <= parityCnt + 1;
    if (rxIf.rx_valid) validCycles <= validCycles + 1;
    if (rxIf.rx_valid && !prevValid) begin
      validRise <= validRise + 1;
      riseCycle <= cycleCnt;
      lastData  <= rxIf.rx_data;
    end
    prevValid <= rxIf.rx_valid;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rxIn = b;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopBit,
                            input logic usePar, input logic parBit);
    startCycle = cycleCnt;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (usePar) send_bit(parBit);
    send_bit(stopBit);
    rxIn = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rxIn = 1'b1;
    rxIf.rx_ready = 1'b1;
    idle(3);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rxIf.rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", rxIf.rx_valid); end
    checks++; if (rxIf.rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h exp=00", rxIf.rx_data); end
    checks++; if ({frameErr, overrunErr, parityErr} !== 3'b000) begin failures++; $display("[TB] FAIL reset_errs got=%b exp=000", {frameErr, overrunErr, parityErr}); end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_basic;
    int r0, v0, f0;
    r0 = validRise; v0 = validCycles; f0 = frameCnt;
    rxIf.rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(10);
    checks++; if (validRise - r0 !== 1) begin failures++; $display("[TB] FAIL basic_rise got=%0d exp=1", validRise - r0); end
    checks++; if (lastData !== 8'hA5) begin failures++; $display("[TB] FAIL basic_data got=%h exp=a5", lastData); end
    checks++; if (validCycles - v0 !== 1) begin failures++; $display("[TB] FAIL basic_valid_len got=%0d exp=1", validCycles - v0); end
    checks++; if (riseCycle - startCycle !== 98) begin failures++; $display("[TB] FAIL basic_latency got=%0d exp=98", riseCycle - startCycle); end
    checks++; if (frameCnt - f0 !== 0) begin failures++; $display("[TB] FAIL basic_frame_err got=%0d exp=0", frameCnt - f0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_glitch;
    int r0, f0;
    r0 = validRise; f0 = frameCnt;
    rxIn = 1'b0;
    idle(3);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL glitch_busy_start got=%b exp=1", busy); end
    rxIn = 1'b1;
    idle(20);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL glitch_busy_after got=%b exp=0", busy); end
    checks++; if (validRise - r0 !== 0) begin failures++; $display("[TB] FAIL glitch_rise got=%0d exp=0", validRise - r0); end
    checks++; if (frameCnt - f0 !== 0) begin failures++; $display("[TB] FAIL glitch_frame_err got=%0d exp=0", frameCnt - f0); end
  endtask

  task automatic test_frame_err;
    int r0, f0;
    r0 = validRise; f0 = frameCnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    rxIn = 1'b0;
    idle(50);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL break_busy got=%b exp=1", busy); end
    checks++; if (frameCnt - f0 !== 1) begin failures++; $display("[TB] FAIL frame_err_count got=%0d exp=1", frameCnt - f0); end
    rxIn = 1'b1;
    idle(20);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL break_exit_busy got=%b exp=0", busy); end
    checks++; if (validRise - r0 !== 0) begin failures++; $display("[TB] FAIL frame_err_rise got=%0d exp=0", validRise - r0); end
    checks++; if (frameCnt - f0 !== 1) begin failures++; $display("[TB] FAIL frame_err_total got=%0d exp=1", frameCnt - f0); end
  endtask

  task automatic test_back_to_back;
    int r0, o0;
    r0 = validRise; o0 = overrunCnt;
    rxIf.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    idle(10);
    checks++; if (overrunCnt - o0 !== 1) begin failures++; $display("[TB] FAIL overrun_count got=%0d exp=1", overrunCnt - o0); end
    checks++; if (rxIf.rx_data !== 8'h11) begin failures++; $display("[TB] FAIL overrun_data got=%h exp=11", rxIf.rx_data); end
    checks++; if (rxIf.rx_valid !== 1'b1) begin failures++; $display("[TB] FAIL overrun_valid got=%b exp=1", rxIf.rx_valid); end
    checks++; if (validRise - r0 !== 1) begin failures++; $display("[TB] FAIL overrun_rise got=%0d exp=1", validRise - r0); end
    rxIf.rx_ready = 1'b1;
    idle(1);
    checks++; if (rxIf.rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL consume_clear got=%b exp=0", rxIf.rx_valid); end
  endtask

  task automatic test_reset_mid_frame;
    int r0, f0, o0, p0;
    r0 = validRise; f0 = frameCnt; o0 = overrunCnt; p0 = parityCnt;
    rxIf.rx_ready = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (rxIf.rx_data !== 8'h00) begin failures++; $display("[TB] FAIL midreset_data got=%h exp=00", rxIf.rx_data); end
    idle(60);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
    idle(10);
    checks++; if (validRise - r0 !== 1) begin failures++; $display("[TB] FAIL midreset_rise got=%0d exp=1", validRise - r0); end
    checks++; if (lastData !== 8'h0F) begin failures++; $display("[TB] FAIL midreset_byte got=%h exp=0f", lastData); end
    checks++; if ((frameCnt - f0) + (overrunCnt - o0) + (parityCnt - p0) !== 0) begin
      failures++; $display("[TB] FAIL midreset_errs got=%0d exp=0", (frameCnt - f0) + (overrunCnt - o0) + (parityCnt - p0));
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int p0;
    rxIf.rx_ready = 1'b1;
    p0 = parityCnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    idle(10);
    checks++; if (lastData !== 8'h07) begin failures++; $display("[TB] FAIL parity_bad_data got=%h exp=07", lastData); end
    checks++; if (parityCnt - p0 !== 1) begin failures++; $display("[TB] FAIL parity_bad_pulse got=%0d exp=1", parityCnt - p0); end
    p0 = parityCnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    idle(10);
    checks++; if (lastData !== 8'h07) begin failures++; $display("[TB] FAIL parity_ok_data got=%h exp=07", lastData); end
    checks++; if (parityCnt - p0 !== 0) begin failures++; $display("[TB] FAIL parity_ok_pulse got=%0d exp=0", parityCnt - p0); end
  endtask
`else
  task automatic test_parity;
    int p0;
    rxIf.rx_ready = 1'b1;
    p0 = parityCnt;
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    idle(10);
    checks++; if (lastData !== 8'h07) begin failures++; $display("[TB] FAIL noparity_data got=%h exp=07", lastData); end
    checks++; if (parityCnt - p0 !== 0) begin failures++; $display("[TB] FAIL noparity_pulse got=%0d exp=0", parityCnt - p0); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    rxIn = 1'b1;
    rxIf.rx_ready = 1'b1;
    test_reset;
    test_basic;
    test_glitch;
    test_frame_err;
    test_back_to_back;
    test_reset_mid_frame;
    test_parity;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
